// File: rtl/game_pkg.sv
// Shared game definitions: blink FSM state encoding, default blink timing
// constants and timer sizing helper used by the LED / buzzer output blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } blink_state_e;

  localparam int DEFAULT_ON_CYCLES  = 4;
  localparam int DEFAULT_OFF_CYCLES = 2;
  localparam int DEFAULT_QUEUE_MAX  = 3;

  // Width of a timer that counts 0..max(on,off)-1, never narrower than 1 bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter saturating at 0 and MAX. Simultaneous inc and dec cancel.
module sat_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count = count_q;
  assign full  = (count_q == MAX_V);
  assign empty = (count_q == '0);

  // Next count: clear wins, then a lone inc or lone dec within the limits.
  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && !full) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && !empty) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so all flops update from pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/event_pulse_stretcher.sv
// Turns one-cycle event strobes into LED blinks of ON_CYCLES high followed
// by at least OFF_CYCLES low. Events arriving mid-blink are queued (up to
// QUEUE_MAX) so bursts give distinct blinks; extra events raise overflow.
module event_pulse_stretcher
  import game_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
  parameter int QUEUE_MAX  = DEFAULT_QUEUE_MAX,
  localparam int PW        = $clog2(QUEUE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  input  logic          clear,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  blink_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          led_q;
  logic          overflow_q, overflow_d;

  logic          q_inc, q_dec, q_clr;
  logic          q_full, q_empty;

  // Pending-blink queue depth.
  sat_counter #(
    .MAX (QUEUE_MAX),
    .W   (PW)
  ) u_pending (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (q_clr),
    .inc   (q_inc),
    .dec   (q_dec),
    .count (pending),
    .full  (q_full),
    .empty (q_empty)
  );

  assign led      = led_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE) || !q_empty;

  // Next-state, timer and queue control for the blink sequencer.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    overflow_d = 1'b0;
    q_inc      = 1'b0;
    q_dec      = 1'b0;
    q_clr      = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
      q_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_in) begin
            state_d = ST_ON;
            timer_d = '0;
          end
        end

        ST_ON: begin
          if (timer_q == ON_LAST) begin
            state_d = ST_GAP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
          if (pulse_in) begin
            if (q_full) overflow_d = 1'b1;
            else        q_inc      = 1'b1;
          end
        end

        ST_GAP: begin
          if (timer_q == OFF_LAST) begin
            if (!q_empty) begin
              // Dequeue; a coincident event takes the freed slot.
              state_d = ST_ON;
              timer_d = '0;
              q_dec   = 1'b1;
              q_inc   = pulse_in;
            end else if (pulse_in) begin
              // Start straight away rather than passing through IDLE.
              state_d = ST_ON;
              timer_d = '0;
            end else begin
              state_d = ST_IDLE;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q + TW'(1);
            if (pulse_in) begin
              if (q_full) overflow_d = 1'b1;
              else        q_inc      = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      led_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      led_q      <= (state_d == ST_ON);
      overflow_q <= overflow_d;
    end
  end

endmodule
